ascii_ram_arbiter: RTL and testbench

ASCII_RAM_ARBITER -- requirements
Module: ascii_ram_arbiter

---
 rtl/ascii_ram_arbiter_if.sv | 30 +++
 rtl/ascii_ram_arbiter.sv | 99 +++++++++
 tb/tb_ascii_ram_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ascii_ram_arbiter_if.sv
// Signal bundle between the ASCII RAM arbiter and its CPU, renderer, clear and RAM neighbours.
interface ascii_ram_arbiter_if #(
  parameter int AW = 12
);
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ready;
  logic          cpu_err;
  logic          vga_re;
  logic [AW-1:0] vga_addr;
  logic [7:0]    vga_rdata;
  logic          vga_rvalid;
  logic          clr_start;
  logic          clr_busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  modport slave (
    input  cpu_we, cpu_addr, cpu_wdata, vga_re, vga_addr, clr_start, ram_rdata,
    output cpu_ready, cpu_err, vga_rdata, vga_rvalid, clr_busy, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output cpu_we, cpu_addr, cpu_wdata, vga_re, vga_addr, clr_start, ram_rdata,
    input  cpu_ready, cpu_err, vga_rdata, vga_rvalid, clr_busy, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/ascii_ram_arbiter.sv
// Shares one single-port character RAM between the renderer (reads), a full-screen
// clear engine and a one-entry buffered CPU write port, with fixed priority in that order.
module ascii_ram_arbiter #(
  parameter int          ROW_BIT  = 5,
  parameter int          COL_BIT  = 7,
  parameter logic [31:0] BASE     = 32'h00EF_FF00,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic               clk,
  input  logic               rst_n,
  ascii_ram_arbiter_if.slave bus
);
  localparam int AW = ROW_BIT + COL_BIT;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clrCnt_q, clrCnt_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] heldAddr_q, heldAddr_d;
  logic [7:0]    heldData_q, heldData_d;
  logic          cpuErr_q, cpuErr_d;
  logic          rvalid_q;
  logic [31:0]   offset;
  logic          inWindow;
  logic          accept;

  // Upper offset bits must be zero so the window is exactly 2^AW bytes above BASE.
  assign offset   = bus.cpu_addr - BASE;
  assign inWindow = (bus.cpu_addr >= BASE) && (offset[31:AW] == '0);
  assign accept   = bus.cpu_we && !pend_q;

  assign bus.cpu_ready  = !pend_q;
  assign bus.cpu_err    = cpuErr_q;
  assign bus.clr_busy   = (state_q == CLEAR);
  assign bus.vga_rvalid = rvalid_q;
  assign bus.vga_rdata  = bus.ram_rdata;

  always_comb begin
    state_d       = state_q;
    clrCnt_d      = clrCnt_q;
    pend_d        = pend_q;
    heldAddr_d    = heldAddr_q;
    heldData_d    = heldData_q;
    cpuErr_d      = accept && !inWindow;
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;

    if (bus.vga_re) begin
      bus.ram_addr = bus.vga_addr;
    end else if (state_q == CLEAR) begin
      bus.ram_addr  = clrCnt_q;
      bus.ram_we    = 1'b1;
      bus.ram_wdata = CLR_CHAR;
      clrCnt_d      = clrCnt_q + 1'b1;
      if (clrCnt_q == '1) begin
        state_d = IDLE;
      end
    end else if (pend_q) begin
      bus.ram_addr  = heldAddr_q;
      bus.ram_we    = 1'b1;
      bus.ram_wdata = heldData_q;
      pend_d        = 1'b0;
    end

    if ((state_q == IDLE) && bus.clr_start) begin
      state_d  = CLEAR;
      clrCnt_d = '0;
    end

    // Capture only happens with the holding register empty, so it never collides with an issue.
    if (accept && inWindow) begin
      pend_d     = 1'b1;
      heldAddr_d = offset[AW-1:0];
      heldData_d = bus.cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clrCnt_q   <= '0;
      pend_q     <= 1'b0;
      heldAddr_q <= '0;
      heldData_q <= '0;
      cpuErr_q   <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clrCnt_q   <= clrCnt_d;
      pend_q     <= pend_d;
      heldAddr_q <= heldAddr_d;
      heldData_q <= heldData_d;
      cpuErr_q   <= cpuErr_d;
      rvalid_q   <= bus.vga_re;
    end
  end
endmodule

// File: tb/tb_ascii_ram_arbiter.sv
// Randomised and directed bench for ascii_ram_arbiter against a cell-level reference model
// plus a behavioural RAM whose final image is compared with the model's expected image.
module tb_ascii_ram_arbiter;
  localparam int     AW    = 12;
  localparam int     CELLS = 1 << AW;
  localparam longint BASE  = 64'h00EF_FF00;

  logic clk = 1'b0;
  logic rst_n;

  ascii_ram_arbiter_if #(.AW(AW)) bus ();

  ascii_ram_arbiter #(
    .ROW_BIT (5),
    .COL_BIT (7),
    .BASE    (32'h00EF_FF00),
    .CLR_CHAR(8'h20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] ramMem [CELLS];
  logic [7:0] rdNext;

  always @(posedge clk) begin
    rdNext = ramMem[bus.ram_addr];
    if (bus.ram_we) ramMem[bus.ram_addr] = bus.ram_wdata;
    bus.ram_rdata <= rdNext;
  end

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: what the screen should contain and which request owns the RAM next.
  logic [7:0] shadow [CELLS];
  bit         mBusy, mPend, mErr, mPrevRe;
  int         mNext, mPendCell;
  logic [7:0] mPendData, mPrevData;

  logic       obsWe, obsReady, obsBusy, obsRvalid, obsErr;
  logic [31:0] obsAddr;
  logic [7:0] obsData, obsRdata;
  int         busyCount, reBusyCount;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mNext = 0; mPend = 0; mErr = 0; mPrevRe = 0;
  endtask

  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [7:0] wd,
                               input bit re, input logic [AW-1:0] vaddr, input bit clr, input bit rstn);
    bit     expWe, grantClr, grantPend, accepted, inWin;
    int     expAddr, expData;
    longint a;
    @(negedge clk);
    bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    bus.vga_re = re; bus.vga_addr = vaddr; bus.clr_start = clr;
    rst_n = rstn;
    #1;
    if (!rstn) modelReset();
    expWe = 0; expAddr = 0; expData = 0; grantClr = 0; grantPend = 0;
    if (re) begin
      expAddr = int'(vaddr);
    end else if (mBusy) begin
      expWe = 1; expAddr = mNext; expData = 'h20; grantClr = 1;
    end else if (mPend) begin
      expWe = 1; expAddr = mPendCell; expData = int'(mPendData); grantPend = 1;
    end
    obsWe = bus.ram_we; obsAddr = 32'(bus.ram_addr); obsData = bus.ram_wdata;
    obsReady = bus.cpu_ready; obsBusy = bus.clr_busy; obsRvalid = bus.vga_rvalid;
    obsRdata = bus.vga_rdata; obsErr = bus.cpu_err;
    checkOutput("ram_we", 32'(obsWe), 32'(expWe));
    checkOutput("ram_addr", obsAddr, expAddr);
    checkOutput("ram_wdata", 32'(obsData), expData);
    checkOutput("cpu_ready", 32'(obsReady), 32'(!mPend));
    checkOutput("cpu_err", 32'(obsErr), 32'(mErr));
    checkOutput("clr_busy", 32'(obsBusy), 32'(mBusy));
    checkOutput("vga_rvalid", 32'(obsRvalid), 32'(mPrevRe));
    if (mPrevRe) checkOutput("vga_rdata", 32'(obsRdata), 32'(mPrevData));
    if (obsBusy) begin
      busyCount++;
      if (re) reBusyCount++;
    end
    @(posedge clk);
    if (rstn) begin
      mPrevRe = re;
      if (re) mPrevData = shadow[vaddr];
      if (expWe) shadow[expAddr] = expData[7:0];
      a = longint'(addr);
      inWin = (a >= BASE) && (a < BASE + CELLS);
      accepted = we && !mPend;
      mErr = accepted && !inWin;
      if (grantPend) mPend = 0;
      if (accepted && inWin) begin
        mPend = 1; mPendCell = int'(a - BASE); mPendData = wd;
      end
      if (grantClr) begin
        if (mNext == CELLS - 1) mBusy = 0;
        else mNext++;
      end else if (!mBusy && clr) begin
        mBusy = 1; mNext = 0;
      end
    end
  endtask

  task automatic idleCycle();
    applyStimulus(0, 32'h0, 8'h0, 0, '0, 0, 1);
  endtask

  initial begin
    logic [31:0] ra;
    int diffs, cleared;
    for (int i = 0; i < CELLS; i++) begin
      ramMem[i] = 8'($urandom);
      shadow[i] = ramMem[i];
    end
    modelReset();
    bus.ram_rdata = 8'h0;

    // Reset state held for a few cycles
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 8'h0, 0, '0, 0, 0);
    checkOutput("rstReady", 32'(obsReady), 1);
    checkOutput("rstBusy", 32'(obsBusy), 0);
    idleCycle();

    // In-window write lands one cycle later at row 1, col 5
    applyStimulus(1, 32'h00EF_FF85, 8'h41, 0, '0, 0, 1);
    idleCycle();
    checkOutput("wrWe", 32'(obsWe), 1);
    checkOutput("wrAddr", obsAddr, 32'h085);
    checkOutput("wrData", 32'(obsData), 32'h41);
    checkOutput("wrReadyLow", 32'(obsReady), 0);
    idleCycle();
    checkOutput("wrReadyBack", 32'(obsReady), 1);

    // Just-outside-window writes are dropped with an error pulse each
    applyStimulus(1, 32'h00EF_FEFF, 8'h11, 0, '0, 0, 1);
    applyStimulus(1, 32'h00F0_0F00, 8'h22, 0, '0, 0, 1);
    checkOutput("errPulse1", 32'(obsErr), 1);
    idleCycle();
    checkOutput("errPulse2", 32'(obsErr), 1);
    checkOutput("errNoWrite", 32'(obsWe), 0);
    idleCycle();
    checkOutput("errCleared", 32'(obsErr), 0);

    // Clear with renderer interleaved, plus a write held across the clear
    busyCount = 0; reBusyCount = 0;
    applyStimulus(0, 32'h0, 8'h0, 0, '0, 1, 1);
    for (int k = 0; k < 8000; k++) begin
      applyStimulus(k == 50, 32'h00EF_FF00, 8'h58, (k % 4) == 0, 12'($urandom), 0, 1);
      if (!obsBusy) break;
    end
    checkOutput("clearDone", 32'(obsBusy), 0);
    checkOutput("clearBusyCycles", busyCount, CELLS + reBusyCount);
    cleared = 0;
    for (int i = 1; i < CELLS; i++) if (ramMem[i] == 8'h20) cleared++;
    checkOutput("clearedCells", cleared, CELLS - 1);
    applyStimulus(0, 32'h0, 8'h0, 1, 12'h000, 0, 1);
    idleCycle();
    checkOutput("readbackValid", 32'(obsRvalid), 1);
    checkOutput("readbackData", 32'(obsRdata), 32'h58);

    // Renderer read beats a pending write; the write follows next cycle
    applyStimulus(1, 32'h00F0_0023, 8'h33, 0, '0, 0, 1);
    applyStimulus(0, 32'h0, 8'h0, 1, 12'h005, 0, 1);
    checkOutput("readWinsWe", 32'(obsWe), 0);
    idleCycle();
    checkOutput("deferredWe", 32'(obsWe), 1);
    checkOutput("deferredAddr", obsAddr, 32'h123);
    checkOutput("deferredRvalid", 32'(obsRvalid), 1);

    // Simultaneous clear start and accepted write
    applyStimulus(1, 32'h00EF_FF07, 8'h77, 0, '0, 1, 1);
    for (int k = 0; k < 5000; k++) begin
      idleCycle();
      if (!obsBusy) break;
    end
    checkOutput("simulClearDone", 32'(obsBusy), 0);
    idleCycle();
    checkOutput("simulReady", 32'(obsReady), 1);

    // Reset in the middle of a clear with a write pending
    applyStimulus(0, 32'h0, 8'h0, 0, '0, 1, 1);
    for (int k = 0; k < 100; k++)
      applyStimulus(k == 10, 32'h00F0_0000, 8'h5A, 0, '0, 0, 1);
    applyStimulus(0, 32'h0, 8'h0, 0, '0, 0, 0);
    checkOutput("midRstBusy", 32'(obsBusy), 0);
    checkOutput("midRstWe", 32'(obsWe), 0);
    applyStimulus(0, 32'h0, 8'h0, 0, '0, 0, 0);
    for (int k = 0; k < 20; k++) idleCycle();
    checkOutput("postRstReady", 32'(obsReady), 1);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    ra = 32'(BASE) + 32'($urandom_range(0, CELLS - 1));
        2:       ra = 32'(BASE) - 32'($urandom_range(1, 16));
        default: ra = ($urandom_range(0, 1) == 1) ? 32'(BASE + CELLS) + 32'($urandom_range(0, 15)) : $urandom;
      endcase
      applyStimulus($urandom_range(0, 2) == 0, ra, 8'($urandom), $urandom_range(0, 2) == 0,
                    12'($urandom), $urandom_range(0, 499) == 0, $urandom_range(0, 999) != 0);
    end
    for (int k = 0; k < 6000; k++) begin
      idleCycle();
      if (!obsBusy && obsReady) break;
    end
    idleCycle();

    diffs = 0;
    for (int i = 0; i < CELLS; i++) if (ramMem[i] !== shadow[i]) diffs++;
    checkOutput("memImage", diffs, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
